// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: word widths, register count and
// the controller micro-op encoding.
package fir_pkg;

    localparam int unsigned DATA_W   = 16;          // external sample/coefficient width
    localparam int unsigned REG_W    = DATA_W + 1;  // signed register word width
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned IDX_W    = 4;           // register index width

    typedef enum logic [2:0] {
        OpNop   = 3'b000,
        OpCopy  = 3'b001,
        OpLoad1 = 3'b010,
        OpLoad2 = 3'b011,
        OpAdd   = 3'b100,
        OpSub   = 3'b101,
        OpMul   = 3'b110,
        OpRsvd  = 3'b111
    } op_e;

endpackage

// File: rtl/fir_regfile.sv
// 16 x REG_W register file for the FIR datapath.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset (clears all entries)
//   raddr1_i/rdata1_o   combinational read port 1
//   raddr2_i/rdata2_o   combinational read port 2
//   we_i, waddr_i,
//   wdata_i             synchronous write port
//   r0_o                dedicated view of register 0 (filter accumulator)
module fir_regfile
    import fir_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] raddr1_i,
    input  logic [IDX_W-1:0] raddr2_i,
    output logic [REG_W-1:0] rdata1_o,
    output logic [REG_W-1:0] rdata2_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [REG_W-1:0] wdata_i,
    output logic [REG_W-1:0] r0_o
);

    logic [REG_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the flop contents, so a same-cycle src==dest reads the old value
    // while the next op sees the freshly written one.
    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];
    assign r0_o     = regs_q[0];

endmodule

// File: rtl/fir_datapath.sv
// FIR filter datapath: executes one controller micro-op per cycle on a
// 16-entry signed register file through a single ALU.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   op, src1, src2, dest  micro-op from the controller
//   ext_data1/ext_data2   external sample/coefficient words for LOAD1/LOAD2
//   overflow              registered overflow flag of the last ADD/SUB/MUL
//   outreg_data           low DATA_W bits of R0 (filter output)
module fir_datapath
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [IDX_W-1:0]  src1,
    input  logic [IDX_W-1:0]  src2,
    input  logic [IDX_W-1:0]  dest,
    input  logic [DATA_W-1:0] ext_data1,
    input  logic [DATA_W-1:0] ext_data2,
    output logic              overflow,
    output logic [DATA_W-1:0] outreg_data
);

    logic [REG_W-1:0]   rdata1;
    logic [REG_W-1:0]   rdata2;
    logic [REG_W-1:0]   r0;
    logic               we;
    logic [REG_W-1:0]   wdata;
    logic               ovf_d, ovf_q;

    logic [REG_W:0]     sum_ext;
    logic [REG_W:0]     diff_ext;
    logic [2*REG_W-1:0] prod;
    logic               sum_ovf, diff_ovf, prod_ovf;

    fir_regfile u_regfile (
        .clk_i    (clk),
        .rst_i    (rst),
        .raddr1_i (src1),
        .raddr2_i (src2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2),
        .we_i     (we),
        .waddr_i  (dest),
        .wdata_i  (wdata),
        .r0_o     (r0)
    );

    // One guard bit: result fits REG_W signed iff the top two bits agree.
    assign sum_ext  = {rdata1[REG_W-1], rdata1} + {rdata2[REG_W-1], rdata2};
    assign diff_ext = {rdata1[REG_W-1], rdata1} - {rdata2[REG_W-1], rdata2};
    assign sum_ovf  = sum_ext[REG_W] ^ sum_ext[REG_W-1];
    assign diff_ovf = diff_ext[REG_W] ^ diff_ext[REG_W-1];

    // Sign-extended operands at full product width give the exact signed product.
    assign prod = {{REG_W{rdata1[REG_W-1]}}, rdata1} * {{REG_W{rdata2[REG_W-1]}}, rdata2};
    // Fits iff every bit from the REG_W sign position upward matches.
    assign prod_ovf = !((&prod[2*REG_W-1:REG_W-1]) || ~(|prod[2*REG_W-1:REG_W-1]));

    always_comb begin
        we    = 1'b0;
        wdata = '0;
        ovf_d = ovf_q;
        case (op_e'(op))
            OpCopy: begin
                we    = 1'b1;
                wdata = rdata1;
            end
            OpLoad1: begin
                we    = 1'b1;
                wdata = {{(REG_W - DATA_W){1'b0}}, ext_data1};
            end
            OpLoad2: begin
                we    = 1'b1;
                wdata = {{(REG_W - DATA_W){1'b0}}, ext_data2};
            end
            OpAdd: begin
                we    = 1'b1;
                wdata = sum_ext[REG_W-1:0];
                ovf_d = sum_ovf;
            end
            OpSub: begin
                we    = 1'b1;
                wdata = diff_ext[REG_W-1:0];
                ovf_d = diff_ovf;
            end
            OpMul: begin
                we    = 1'b1;
                wdata = prod[REG_W-1:0];
                ovf_d = prod_ovf;
            end
            default: ; // NOP and reserved: no write, flag holds
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow    = ovf_q;
    assign outreg_data = r0[DATA_W-1:0];

endmodule

// File: tb/tb_fir_datapath.sv
module tb_fir_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [3:0]  src1, src2, dest;
    logic [15:0] ext_data1, ext_data2;
    logic        overflow;
    logic [15:0] outreg_data;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model: registers as plain signed integers.
    longint mregs [16];
    bit     movf;

    always #5 clk = ~clk;

    fir_datapath dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .src1        (src1),
        .src2        (src2),
        .dest        (dest),
        .ext_data1   (ext_data1),
        .ext_data2   (ext_data2),
        .overflow    (overflow),
        .outreg_data (outreg_data)
    );

    // Reduce an integer modulo 2^17 into the signed 17-bit range.
    function automatic longint wrap17(input longint x);
        longint t;
        t = x % 131072;
        if (t < 0) t += 131072;
        if (t >= 65536) t -= 131072;
        return t;
    endfunction

    function automatic bit fits17(input longint x);
        return (x >= -65536) && (x <= 65535);
    endfunction

    function automatic logic [15:0] model_out();
        longint t;
        t = mregs[0] % 65536;
        if (t < 0) t += 65536;
        return t[15:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 0;
        movf = 1'b0;
    endtask

    task automatic model_exec(input int o, input int s1, input int s2, input int d,
                              input int e1, input int e2);
        longint r;
        case (o)
            1: mregs[d] = mregs[s1];
            2: mregs[d] = e1;
            3: mregs[d] = e2;
            4, 5, 6: begin
                if (o == 4)      r = mregs[s1] + mregs[s2];
                else if (o == 5) r = mregs[s1] - mregs[s2];
                else             r = mregs[s1] * mregs[s2];
                movf     = !fits17(r);
                mregs[d] = wrap17(r);
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one op, let it execute on the next rising edge, then compare both outputs.
    task automatic do_op(input string tag, input int o, input int s1, input int s2,
                         input int d, input int e1, input int e2);
        op        = 3'(o);
        src1      = 4'(s1);
        src2      = 4'(s2);
        dest      = 4'(d);
        ext_data1 = 16'(e1);
        ext_data2 = 16'(e2);
        @(posedge clk);
        model_exec(o, s1, s2, d, e1, e2);
        #1;
        check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, movf});
        check({tag, ".out"}, {16'b0, outreg_data}, {16'b0, model_out()});
    endtask

    initial begin
        rst = 1'b1;
        op = '0; src1 = '0; src2 = '0; dest = '0; ext_data1 = '0; ext_data2 = '0;
        model_reset();
        #12;
        check("reset.ovf", {31'b0, overflow}, 32'd0);
        check("reset.out", {16'b0, outreg_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load / copy
        do_op("load1", 2, 0, 0, 1, 16'h1234, 0);
        do_op("copy", 1, 1, 0, 0, 0, 0);
        check("copy.out", {16'b0, outreg_data}, 32'h1234);
        check("copy.ovf", {31'b0, overflow}, 32'd0);

        // ADD 65535+1 = 65536 lies outside signed 17-bit range
        do_op("ld_ffff", 2, 0, 0, 1, 16'hFFFF, 0);
        do_op("ld_1", 3, 0, 0, 2, 0, 1);
        do_op("add_r3", 4, 1, 2, 3, 0, 0);
        check("add65536.ovf", {31'b0, overflow}, 32'd1);
        do_op("cp_r3", 1, 3, 0, 0, 0, 0);
        check("add65536.out", {16'b0, outreg_data}, 32'h0000);
        do_op("sub_r4", 5, 2, 1, 4, 0, 0);
        check("sub.ovf", {31'b0, overflow}, 32'd0);
        do_op("cp_r4", 1, 4, 0, 0, 0, 0);
        check("sub.out", {16'b0, outreg_data}, 32'h0002);

        // Overflow set, hold, clear
        do_op("ld2_ffff", 3, 0, 0, 2, 0, 16'hFFFF);
        do_op("add_ovf", 4, 1, 2, 0, 0, 0);
        check("addovf.ovf", {31'b0, overflow}, 32'd1);
        check("addovf.out", {16'b0, outreg_data}, 32'hFFFE);
        do_op("nop", 0, 0, 0, 0, 0, 0);
        check("nophold.ovf", {31'b0, overflow}, 32'd1);
        do_op("ld_1b", 2, 0, 0, 1, 1, 0);
        do_op("add_ok", 4, 1, 1, 0, 0, 0);
        check("addclr.ovf", {31'b0, overflow}, 32'd0);
        check("addclr.out", {16'b0, outreg_data}, 32'd2);

        // MUL
        do_op("ld_300", 2, 0, 0, 1, 300, 0);
        do_op("ld_200", 3, 0, 0, 2, 0, 200);
        do_op("mul_ok", 6, 1, 2, 0, 0, 0);
        check("mul.out", {16'b0, outreg_data}, 32'd60000);
        check("mul.ovf", {31'b0, overflow}, 32'd0);
        do_op("ld_1000a", 2, 0, 0, 1, 1000, 0);
        do_op("ld_1000b", 3, 0, 0, 2, 0, 1000);
        do_op("mul_ovf", 6, 1, 2, 3, 0, 0);
        check("mulovf.ovf", {31'b0, overflow}, 32'd1);

        // Back-to-back hazard
        do_op("ld2_7", 3, 0, 0, 2, 0, 7);
        do_op("add_hz", 4, 2, 2, 2, 0, 0);
        do_op("cp_hz", 1, 2, 0, 0, 0, 0);
        check("hazard.out", {16'b0, outreg_data}, 32'd14);

        // Reserved op: nothing changes (flag set beforehand)
        do_op("mul_ovf2", 6, 1, 1, 5, 0, 0);
        do_op("rsvd", 7, 1, 2, 0, 16'hAAAA, 16'h5555);
        check("rsvd.ovf", {31'b0, overflow}, 32'd1);
        check("rsvd.out", {16'b0, outreg_data}, 32'd14);

        // R15 is an ordinary register
        do_op("ld_r15", 2, 0, 0, 15, 16'h55AA, 0);
        do_op("cp_r15", 1, 15, 0, 0, 0, 0);
        check("r15.out", {16'b0, outreg_data}, 32'h55AA);

        // Mid-clock reset after loading R5, with an op pending across an edge
        do_op("ld_r5", 2, 0, 0, 5, 100, 0);
        do_op("add_set", 4, 0, 0, 0, 0, 0);
        op = 3'd2; dest = 4'd0; ext_data1 = 16'hBEEF;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst.ovf", {31'b0, overflow}, 32'd0);
        check("midrst.out", {16'b0, outreg_data}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        op = 3'd0;
        check("abort.out", {16'b0, outreg_data}, 32'd0);
        do_op("cp_r5", 1, 5, 0, 0, 0, 0);
        check("r5clr.out", {16'b0, outreg_data}, 32'd0);

        // Randomized ops against the model; R0 favoured as dest to keep results visible
        for (int k = 0; k < 400; k++) begin
            int o, s1, s2, d;
            o  = $urandom_range(0, 7);
            s1 = $urandom_range(0, 15);
            s2 = ($urandom_range(0, 7) == 0) ? s1 : $urandom_range(0, 15);
            d  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
            do_op("rand", o, s1, s2, d, $urandom_range(0, 65535), $urandom_range(0, 65535));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
